// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 Set-2 keyboard receiver and translator for the 8-bit computer.
// Receives 11-bit PS/2 frames, tracks shift/ctrl state, translates make codes
// to 7-bit uppercase ASCII and holds them with a strobe for the CPU.
//
// Ports
//   phi       in   system clock (posedge)
//   rst       in   synchronous active-high reset
//   ps2_clk   in   PS/2 clock, asynchronous
//   ps2_dat   in   PS/2 data, asynchronous
//   kbd_clr   in   level; clears the strobe bit every cycle it is high
//   kbd       out  [7] strobe (new key), [6:0] ASCII
//   kbd_strb  out  [7] any-key-down, [6:0] zero
//
// Receiver states
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (data low on a falling PS/2 clock)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | checking stop bit and odd parity, then back to idle

module kbd_ctrl #(
   parameter int TIMEOUT = 250
) (
   input  logic       phi,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic       kbd_clr,
   output logic [7:0] kbd,
   output logic [7:0] kbd_strb
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   rx_state_t state, state_next;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_prev;
   logic          clk_s;
   logic          dat_s;
   logic          fall;

   logic [7:0]    shift_reg;
   logic [2:0]    bit_cnt;
   logic          parity;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          frame_ok;
   logic          rx_valid;
   logic [7:0]    rx_byte;

   logic          brk;
   logic          ext;
   logic          shift_on;
   logic          ctrl_on;
   logic [7:0]    last_make;
   logic          strobe;
   logic [6:0]    ascii_reg;
   logic          key_down;

   logic          key_hit;
   logic [6:0]    key_ascii;
   logic [6:0]    letter_asc;
   logic [6:0]    digit_asc;

   // Synchronizers reset high so a held-idle bus never looks like a falling edge.
   always_ff @(posedge phi) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         clk_prev <= clk_sync[1];
      end
   end

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];
   assign fall  = clk_prev & ~clk_s;

   always_ff @(posedge phi) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_ok   = 1'b0;
      tmo_hit    = (state != RX_IDLE) && (tmo_cnt == TW'(TIMEOUT));
      if (fall) begin
         case (state)
            RX_IDLE:   if (!dat_s) state_next = RX_DATA;
            RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
            RX_PARITY: state_next = RX_STOP;
            RX_STOP: begin
               state_next = RX_IDLE;
               frame_ok   = dat_s & (^{shift_reg, parity});
            end
            default:   state_next = RX_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_next = RX_IDLE;
      end
   end

   always_ff @(posedge phi) begin
      if (rst) begin
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         parity    <= 1'b0;
         tmo_cnt   <= '0;
         rx_valid  <= 1'b0;
         rx_byte   <= 8'h00;
      end else begin
         rx_valid <= frame_ok;
         if (frame_ok) rx_byte <= shift_reg;

         if (state == RX_IDLE || fall || tmo_hit) tmo_cnt <= '0;
         else                                     tmo_cnt <= tmo_cnt + 1'b1;

         if (fall) begin
            case (state)
               RX_IDLE:   bit_cnt <= 3'd0;
               RX_DATA: begin
                  shift_reg <= {dat_s, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
               RX_PARITY: parity <= dat_s;
               default:   ;
            endcase
         end
      end
   end

   function automatic logic [6:0] letter_of(input logic [7:0] sc);
      case (sc)
         8'h1C: return 7'h41;  8'h32: return 7'h42;  8'h21: return 7'h43;
         8'h23: return 7'h44;  8'h24: return 7'h45;  8'h2B: return 7'h46;
         8'h34: return 7'h47;  8'h33: return 7'h48;  8'h43: return 7'h49;
         8'h3B: return 7'h4A;  8'h42: return 7'h4B;  8'h4B: return 7'h4C;
         8'h3A: return 7'h4D;  8'h31: return 7'h4E;  8'h44: return 7'h4F;
         8'h4D: return 7'h50;  8'h15: return 7'h51;  8'h2D: return 7'h52;
         8'h1B: return 7'h53;  8'h2C: return 7'h54;  8'h3C: return 7'h55;
         8'h2A: return 7'h56;  8'h1D: return 7'h57;  8'h22: return 7'h58;
         8'h35: return 7'h59;  8'h1A: return 7'h5A;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] digit_of(input logic [7:0] sc, input logic sh);
      case (sc)
         8'h16: return sh ? 7'h21 : 7'h31;
         8'h1E: return sh ? 7'h40 : 7'h32;
         8'h26: return sh ? 7'h23 : 7'h33;
         8'h25: return sh ? 7'h24 : 7'h34;
         8'h2E: return sh ? 7'h25 : 7'h35;
         8'h36: return sh ? 7'h5E : 7'h36;
         8'h3D: return sh ? 7'h26 : 7'h37;
         8'h3E: return sh ? 7'h2A : 7'h38;
         8'h46: return sh ? 7'h28 : 7'h39;
         8'h45: return sh ? 7'h29 : 7'h30;
         default: return 7'h00;
      endcase
   endfunction

   // A zero from the lookup functions means "not this class of key".
   always_comb begin
      key_hit    = 1'b0;
      key_ascii  = 7'h00;
      letter_asc = letter_of(rx_byte);
      digit_asc  = digit_of(rx_byte, shift_on);
      if (ext) begin
         if (rx_byte == 8'h5A) begin
            key_hit   = 1'b1;
            key_ascii = 7'h0D;
         end
      end else if (letter_asc != 7'h00) begin
         key_hit   = 1'b1;
         key_ascii = ctrl_on ? (letter_asc - 7'h40) : letter_asc;
      end else if (digit_asc != 7'h00) begin
         key_hit   = 1'b1;
         key_ascii = digit_asc;
      end else begin
         case (rx_byte)
            8'h29: begin key_hit = 1'b1; key_ascii = 7'h20; end
            8'h5A: begin key_hit = 1'b1; key_ascii = 7'h0D; end
            8'h66: begin key_hit = 1'b1; key_ascii = 7'h08; end
            8'h76: begin key_hit = 1'b1; key_ascii = 7'h1B; end
            default: ;
         endcase
      end
   end

   // The clear is applied first so a make landing on the same edge overrides it.
   always_ff @(posedge phi) begin
      if (rst) begin
         brk       <= 1'b0;
         ext       <= 1'b0;
         shift_on  <= 1'b0;
         ctrl_on   <= 1'b0;
         last_make <= 8'h00;
         strobe    <= 1'b0;
         ascii_reg <= 7'h00;
         key_down  <= 1'b0;
      end else begin
         if (kbd_clr) strobe <= 1'b0;
         if (rx_valid) begin
            if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
               if (!ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) shift_on <= ~brk;
               if (rx_byte == 8'h14) ctrl_on <= ~brk;
               if (brk) begin
                  if (rx_byte == last_make) key_down <= 1'b0;
               end else if (key_hit) begin
                  strobe    <= 1'b1;
                  ascii_reg <= key_ascii;
                  last_make <= rx_byte;
                  key_down  <= 1'b1;
               end
            end
         end
      end
   end

   assign kbd      = {strobe, ascii_reg};
   assign kbd_strb = {key_down, 7'b0};

endmodule

// File: tb/tb_kbd_ctrl.sv
// Self-checking bench for kbd_ctrl: table of PS/2 frames with expected outputs
// routed through a scoreboard queue, plus hand-written timing and corner cases.

module tb_kbd_ctrl;

   logic       phi = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_dat;
   logic       kbd_clr;
   logic [7:0] kbd;
   logic [7:0] kbd_strb;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] code;
      bit         par_ok;
      bit         stop;
      logic [7:0] exp_kbd;
      logic [7:0] exp_strb;
   } vec_t;

   typedef struct {
      logic [7:0] k;
      logic [7:0] s;
      int         idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   kbd_ctrl #(.TIMEOUT(250)) dut (
      .phi      (phi),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_dat  (ps2_dat),
      .kbd_clr  (kbd_clr),
      .kbd      (kbd),
      .kbd_strb (kbd_strb)
   );

   always #5 phi = ~phi;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [7:0] c, input bit p, input bit s,
                               input logic [7:0] k, input logic [7:0] st);
      vec_t v;
      v.code = c; v.par_ok = p; v.stop = s; v.exp_kbd = k; v.exp_strb = st;
      tbl.push_back(v);
   endfunction

   // One PS/2 bit is 80 phi: data set 20 cycles before the falling edge.
   task automatic bit_low(input logic d);
      @(negedge phi);
      ps2_dat = d;
      repeat (19) @(negedge phi);
      ps2_clk = 1'b0;
   endtask

   task automatic bit_high();
      repeat (40) @(negedge phi);
      ps2_clk = 1'b1;
      repeat (20) @(negedge phi);
   endtask

   task automatic frame_to_stop(input logic [7:0] b, input bit par_ok, input bit stop);
      logic [10:0] f;
      f = {stop, (~^b) ^ ~par_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bit_low(f[i]);
         bit_high();
      end
      bit_low(f[10]);
   endtask

   task automatic frame_end();
      bit_high();
      ps2_dat = 1'b1;
      repeat (20) @(negedge phi);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
      frame_to_stop(b, par_ok, stop);
      frame_end();
   endtask

   task automatic run_table(input int lo, input int hi);
      exp_t e;
      exp_t g;
      for (int i = lo; i < hi; i++) begin
         e.k = tbl[i].exp_kbd;
         e.s = tbl[i].exp_strb;
         e.idx = i;
         sb.push_back(e);
         send_frame(tbl[i].code, tbl[i].par_ok, tbl[i].stop);
         g = sb.pop_front();
         check($sformatf("vec%0d kbd", g.idx), kbd, g.k);
         check($sformatf("vec%0d kbd_strb", g.idx), kbd_strb, g.s);
      end
   endtask

   initial begin
      // code, parity ok, stop, expected kbd, expected kbd_strb
      add(8'hF0, 1, 1, 8'hC1, 8'h80);  // 0
      add(8'h1C, 1, 1, 8'hC1, 8'h00);
      add(8'h12, 1, 1, 8'hC1, 8'h00);
      add(8'h16, 1, 1, 8'hA1, 8'h80);  // shift-1 = !
      add(8'hF0, 1, 1, 8'hA1, 8'h80);
      add(8'h16, 1, 1, 8'hA1, 8'h00);
      add(8'hF0, 1, 1, 8'hA1, 8'h00);
      add(8'h12, 1, 1, 8'hA1, 8'h00);
      add(8'h16, 1, 1, 8'hB1, 8'h80);  // 1
      add(8'h14, 1, 1, 8'hB1, 8'h80);
      add(8'h22, 1, 1, 8'h98, 8'h80);  // ctrl-X
      add(8'hE0, 1, 1, 8'h98, 8'h80);
      add(8'h5A, 1, 1, 8'h8D, 8'h80);  // keypad Enter
      add(8'hE0, 1, 1, 8'h8D, 8'h80);
      add(8'h75, 1, 1, 8'h8D, 8'h80);  // up arrow ignored
      add(8'hF0, 1, 1, 8'h8D, 8'h80);
      add(8'h14, 1, 1, 8'h8D, 8'h80);  // ctrl released
      add(8'h1C, 1, 1, 8'hC1, 8'h80);  // 17
      add(8'h29, 0, 1, 8'hC2, 8'h80);  // 18: bad parity
      add(8'h29, 1, 0, 8'hC2, 8'h80);  // bad stop
      add(8'h29, 1, 1, 8'hA0, 8'h80);  // space
      add(8'h12, 1, 1, 8'hA0, 8'h80);
      add(8'h45, 1, 1, 8'hA9, 8'h80);  // shift-0 = )
      add(8'h1C, 1, 1, 8'hC1, 8'h80);  // letter ignores shift
      add(8'hF0, 1, 1, 8'hC1, 8'h80);
      add(8'h12, 1, 1, 8'hC1, 8'h80);
      add(8'h66, 1, 1, 8'h88, 8'h80);  // backspace
      add(8'h76, 1, 1, 8'h9B, 8'h80);  // esc
      add(8'hF0, 1, 1, 8'h9B, 8'h80);
      add(8'h76, 1, 1, 8'h9B, 8'h00);
      add(8'h4D, 1, 1, 8'hD0, 8'h80);  // P
      add(8'hE0, 1, 1, 8'hD0, 8'h80);
      add(8'h14, 1, 1, 8'hD0, 8'h80);  // right ctrl
      add(8'h1A, 1, 1, 8'h9A, 8'h80);  // ctrl-Z
      add(8'hE0, 1, 1, 8'h9A, 8'h80);
      add(8'hF0, 1, 1, 8'h9A, 8'h80);
      add(8'h14, 1, 1, 8'h9A, 8'h80);
      add(8'h1A, 1, 1, 8'hDA, 8'h80);  // 37: Z

      rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; kbd_clr = 1'b0;
      repeat (4) @(negedge phi);
      check("reset kbd", kbd, 8'h00);
      check("reset kbd_strb", kbd_strb, 8'h00);
      rst = 1'b0;
      repeat (10) @(negedge phi);

      // Output appears exactly two cycles after the stop edge is detected.
      frame_to_stop(8'h1C, 1, 1);
      repeat (3) @(posedge phi);
      #1 check("latency early kbd", kbd, 8'h00);
      @(posedge phi);
      #1 check("latency kbd", kbd, 8'hC1);
      check("latency kbd_strb", kbd_strb, 8'h80);
      frame_end();

      run_table(0, 18);

      @(negedge phi) kbd_clr = 1'b1;
      @(negedge phi) kbd_clr = 1'b0;
      check("clr pulse kbd", kbd, 8'h41);
      check("clr pulse kbd_strb", kbd_strb, 8'h80);

      // kbd_clr high on the same edge the new make lands.
      frame_to_stop(8'h32, 1, 1);
      repeat (3) @(posedge phi);
      @(negedge phi) kbd_clr = 1'b1;
      @(negedge phi) kbd_clr = 1'b0;
      check("clr+make kbd", kbd, 8'hC2);
      frame_end();

      run_table(18, tbl.size());

      // Partial frame abandoned long enough to time out.
      bit_low(1'b0);
      bit_high();
      for (int i = 0; i < 4; i++) begin
         bit_low(i[0]);
         bit_high();
      end
      ps2_dat = 1'b1;
      repeat (300) @(negedge phi);
      send_frame(8'h5A, 1, 1);
      check("timeout kbd", kbd, 8'h8D);
      check("timeout kbd_strb", kbd_strb, 8'h80);

      // Shift held, then reset in the middle of a frame.
      send_frame(8'h12, 1, 1);
      bit_low(1'b0);
      bit_high();
      bit_low(1'b1);
      @(negedge phi) rst = 1'b1;
      @(negedge phi) rst = 1'b0;
      check("mid rst kbd", kbd, 8'h00);
      check("mid rst kbd_strb", kbd_strb, 8'h00);
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (100) @(negedge phi);
      send_frame(8'h16, 1, 1);
      check("post rst kbd", kbd, 8'hB1);
      check("post rst kbd_strb", kbd_strb, 8'h80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
